goomba_scheduler: RTL and testbench
===================================

GOOMBA_SCHEDULER -- requirements
Module: goomba_scheduler

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 4: number of goomba slots, legal range 1-8.
REQ-002 SHALL have parameter SPAWN_PERIOD, default 64: movement ticks between spawn attempts, legal range 1-1023.
REQ-003 SHALL have parameter SPAWN_X, default 600: spawn x pixel.
REQ-004 SHALL have parameter RSP_TIMEOUT, default 15: maximum vga_clock cycles in WAIT.
REQ-005 SHALL have port vga_clock, input, 1: single clock.
REQ-006 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port movement_tick, input, 1: one-cycle pulse per movement step, synchronous to vga_clock.
REQ-008 SHALL have ports mario_x and mario_y, input, int each: Mario position, forwarded to the mover.
REQ-009 SHALL have ports req_valid (output, 1), req_slot (output, 3), req_x (output, int), req_dir (output, 1; 0 = left): shared mover request.
REQ-010 SHALL have port req_ready, input, 1: mover accepts the request.
REQ-011 SHALL have ports rsp_valid (input, 1), rsp_x (input, int), rsp_dir (input, 1), rsp_hit (input, 1), rsp_stomped (input, 1): mover result.
REQ-012 SHALL have ports goomba_x (output, int[NUM_SLOTS]) and goomba_alive (output, NUM_SLOTS): per-slot state.
REQ-013 SHALL have ports lose (output, 1), tick_overrun (output, 1) and rsp_timeout (output, 1): sticky status flags.

Function
REQ-014 SHALL implement states IDLE, ISSUE, WAIT, COMMIT and SPAWN.
REQ-015 SHALL, in IDLE on a movement_tick or a set tick_pending, clear tick_pending, set slot index 0 and enter ISSUE.
REQ-016 SHALL, in ISSUE, skip slots that are not alive by incrementing the index, one slot per cycle.
REQ-017 SHALL, in ISSUE for an alive slot, assert req_valid with req_slot, req_x and req_dir driven from that slot's state.
REQ-018 SHALL hold req_valid and req_* stable until req_valid and req_ready are high in the same cycle, then enter WAIT.
REQ-019 SHALL, in WAIT, accept exactly one rsp_valid, ignore rsp_valid in every other state, and enter COMMIT on the cycle after rsp_valid.
REQ-020 SHALL, in COMMIT, free the slot (alive = 0) when rsp_stomped = 1.
REQ-021 SHALL, in COMMIT when rsp_stomped = 0, write rsp_x and rsp_dir into the slot.
REQ-022 SHALL, in COMMIT, set lose when rsp_hit = 1 and rsp_stomped = 0; stomped takes priority over hit.
REQ-023 SHALL, after COMMIT, advance to the next slot; after slot NUM_SLOTS-1 it SHALL enter SPAWN.
REQ-024 SHALL, when WAIT reaches RSP_TIMEOUT cycles without rsp_valid, set rsp_timeout, leave the slot unchanged and advance as after COMMIT.
REQ-025 SHALL keep a spawn counter (10 bit) that increments once per SPAWN state entry and wraps to 0 at SPAWN_PERIOD-1.
REQ-026 SHALL, in SPAWN when the counter wraps and a free slot exists, set the lowest-index free slot to alive = 1, x = SPAWN_X, dir = 0.
REQ-027 SHALL consume the spawn attempt and change no slot when all slots are alive.
REQ-028 SHALL leave SPAWN for IDLE after exactly one cycle.
REQ-029 SHALL, when movement_tick arrives outside IDLE, set tick_pending; if tick_pending is already set it SHALL drop the tick and set tick_overrun.
REQ-030 SHALL, once lose = 1, freeze all slot state and hold the FSM in IDLE, ignoring ticks, until reset.
REQ-031 SHALL give goomba_x and goomba_alive one-cycle latency from COMMIT or SPAWN to the outputs.
REQ-032 SHALL, at the end of each sweep with no alive slot, still execute the SPAWN state.

Reset
REQ-033 SHALL, while reset = 0, force: FSM to IDLE; all goomba_alive to 0; all goomba_x to 0; all dir to 0.
REQ-034 SHALL, while reset = 0, force to 0: spawn counter, tick_pending, lose, tick_overrun, rsp_timeout, req_valid.
REQ-035 SHALL, when reset asserts mid-transaction (ISSUE or WAIT), drop the transaction and ignore any later rsp_valid.

Verification
REQ-036 SHALL cover SPAWN_PERIOD = 2 with mover always ready and echoing its inputs: 2 ticks -> slot 0 alive, x = 600, dir = 0.
REQ-037 SHALL cover slots 0 and 2 alive with the mover returning x-1: each tick -> exactly two requests in slot order 0 then 2, goomba_x decreases by 1.
REQ-038 SHALL cover a response with rsp_hit = 1 and rsp_stomped = 1: slot freed, lose = 0.
REQ-039 SHALL cover a response with rsp_hit = 1 alone: lose = 1; further ticks -> no requests.
REQ-040 SHALL cover req_ready held low for 5 cycles: req_* stable for those 5 cycles; 2 ticks during them -> tick_pending set, tick_overrun = 1.
REQ-041 SHALL cover no rsp_valid for 15 cycles: rsp_timeout = 1, slot x unchanged; asserting reset while in WAIT -> all outputs return to 0.

Source files
------------

// File: rtl/goomba_scheduler.sv
// Sequences goomba slots through a shared mover: one request per alive slot per
// movement tick, commits the mover's result, and periodically spawns new goombas.
module goomba_scheduler #(
  parameter int NUM_SLOTS    = 4,
  parameter int SPAWN_PERIOD = 64,
  parameter int SPAWN_X      = 600,
  parameter int RSP_TIMEOUT  = 15
) (
  input  logic               vga_clock,
  input  logic               reset,
  input  logic               movement_tick,
  input  logic signed [31:0] mario_x,
  input  logic signed [31:0] mario_y,
  output logic               req_valid,
  output logic [2:0]         req_slot,
  output logic signed [31:0] req_x,
  output logic               req_dir,
  input  logic               req_ready,
  input  logic               rsp_valid,
  input  logic signed [31:0] rsp_x,
  input  logic               rsp_dir,
  input  logic               rsp_hit,
  input  logic               rsp_stomped,
  output logic signed [31:0] goomba_x [NUM_SLOTS],
  output logic [NUM_SLOTS-1:0] goomba_alive,
  output logic               lose,
  output logic               tick_overrun,
  output logic               rsp_timeout
);

  localparam logic [2:0]         LAST_SLOT  = 3'(NUM_SLOTS - 1);
  localparam logic [9:0]         SPAWN_WRAP = 10'(SPAWN_PERIOD - 1);
  localparam logic [15:0]        WAIT_LAST  = 16'(RSP_TIMEOUT - 1);
  localparam logic signed [31:0] SPAWN_XV   = 32'(SPAWN_X);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, COMMIT, SPAWN} state_t;

  state_t state, state_nx;
  logic [2:0]  idx, idx_nx;
  logic [15:0] wait_cnt;
  logic [9:0]  spawn_cnt;
  logic        tick_pending;

  // Storage is sized for the maximum slot count so a 3-bit index never overruns it.
  logic signed [31:0] slot_x [8];
  logic [7:0]         slot_alive;
  logic [7:0]         slot_dir;

  logic signed [31:0] rsp_x_q;
  logic               rsp_dir_q, rsp_hit_q, rsp_stomped_q;

  logic       last_slot, start_sweep, timed_out, free_found;
  logic [2:0] free_idx;

  // Mario position belongs to the mover; nothing in the scheduler consumes it.
  logic unused_mario;
  assign unused_mario = ^{mario_x, mario_y};

  assign last_slot   = (idx == LAST_SLOT);
  assign start_sweep = (state == IDLE) && !lose && (movement_tick || tick_pending);
  assign timed_out   = (state == WAIT) && !rsp_valid && (wait_cnt == WAIT_LAST);

  always_comb begin
    free_found = 1'b0;
    free_idx   = 3'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_alive[i]) begin
        free_found = 1'b1;
        free_idx   = 3'(i);
      end
    end
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      IDLE: begin
        if (start_sweep) begin
          state_nx = ISSUE;
          idx_nx   = 3'd0;
        end
      end
      ISSUE: begin
        if (!slot_alive[idx]) begin
          if (last_slot) state_nx = SPAWN;
          else           idx_nx   = idx + 3'd1;
        end else if (req_ready) begin
          state_nx = WAIT;
        end
      end
      WAIT: begin
        if (rsp_valid) begin
          state_nx = COMMIT;
        end else if (timed_out) begin
          state_nx = last_slot ? SPAWN : ISSUE;
          idx_nx   = last_slot ? idx : idx + 3'd1;
        end
      end
      COMMIT: begin
        if (rsp_hit_q && !rsp_stomped_q) begin
          state_nx = IDLE;
        end else begin
          state_nx = last_slot ? SPAWN : ISSUE;
          idx_nx   = last_slot ? idx : idx + 3'd1;
        end
      end
      SPAWN:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_valid = (state == ISSUE) && slot_alive[idx];
    req_slot  = idx;
    req_x     = slot_x[idx];
    req_dir   = slot_dir[idx];
  end

  always_ff @(posedge vga_clock or negedge reset) begin
    if (!reset) begin
      idx          <= 3'd0;
      wait_cnt     <= 16'd0;
      spawn_cnt    <= 10'd0;
      tick_pending <= 1'b0;
      tick_overrun <= 1'b0;
      rsp_timeout  <= 1'b0;
      lose         <= 1'b0;
      slot_alive   <= 8'd0;
      slot_dir     <= 8'd0;
      for (int i = 0; i < 8; i++) slot_x[i] <= 32'sd0;
    end else begin
      idx <= idx_nx;
      if (state == ISSUE)     wait_cnt <= 16'd0;
      else if (state == WAIT) wait_cnt <= wait_cnt + 16'd1;
      if (timed_out) rsp_timeout <= 1'b1;

      // A tick during a sweep is queued once; a second one is dropped.
      if (start_sweep) begin
        tick_pending <= 1'b0;
      end else if (movement_tick && !lose && state != IDLE) begin
        if (tick_pending) tick_overrun <= 1'b1;
        else              tick_pending <= 1'b1;
      end

      if (state == COMMIT) begin
        if (rsp_stomped_q) begin
          slot_alive[idx] <= 1'b0;
        end else begin
          slot_x[idx]   <= rsp_x_q;
          slot_dir[idx] <= rsp_dir_q;
          if (rsp_hit_q) lose <= 1'b1;
        end
      end

      if (state == SPAWN) begin
        if (spawn_cnt == SPAWN_WRAP) begin
          spawn_cnt <= 10'd0;
          if (free_found) begin
            slot_alive[free_idx] <= 1'b1;
            slot_x[free_idx]     <= SPAWN_XV;
            slot_dir[free_idx]   <= 1'b0;
          end
        end else begin
          spawn_cnt <= spawn_cnt + 10'd1;
        end
      end
    end
  end

  // Response payload is only meaningful in the COMMIT that follows its capture.
  always_ff @(posedge vga_clock) begin
    if (state == WAIT && rsp_valid) begin
      rsp_x_q       <= rsp_x;
      rsp_dir_q     <= rsp_dir;
      rsp_hit_q     <= rsp_hit;
      rsp_stomped_q <= rsp_stomped;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SLOTS; i++) goomba_x[i] = slot_x[i];
    goomba_alive = slot_alive[NUM_SLOTS-1:0];
  end

endmodule

// File: tb/tb_goomba_scheduler.sv
// Directed bench for goomba_scheduler with a small mover model answering requests.
module tb_goomba_scheduler;

  logic               vga_clock = 1'b0;
  logic               reset = 1'b1;
  logic               movement_tick = 1'b0;
  logic signed [31:0] mario_x = 32'sd100;
  logic signed [31:0] mario_y = 32'sd200;
  logic               req_valid;
  logic [2:0]         req_slot;
  logic signed [31:0] req_x;
  logic               req_dir;
  logic               req_ready = 1'b1;
  logic               rsp_valid = 1'b0;
  logic signed [31:0] rsp_x = 32'sd0;
  logic               rsp_dir = 1'b0;
  logic               rsp_hit = 1'b0;
  logic               rsp_stomped = 1'b0;
  logic signed [31:0] goomba_x [4];
  logic [3:0]         goomba_alive;
  logic               lose, tick_overrun, rsp_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  // Mover model controls and request log
  logic mv_respond = 1'b1;
  int   mv_dx = 0;
  logic mv_hit = 1'b0;
  int   mv_stomp_slot = -1;
  logic inject_rsp = 1'b0;
  int   req_log [$];
  int   req_xlog [$];
  int   req_dlog [$];
  logic pend = 1'b0;
  int   pend_x = 0;
  int   pend_slot = 0;
  logic pend_dir = 1'b0;

  goomba_scheduler #(
    .NUM_SLOTS(4), .SPAWN_PERIOD(2), .SPAWN_X(600), .RSP_TIMEOUT(15)
  ) dut (
    .vga_clock(vga_clock), .reset(reset), .movement_tick(movement_tick),
    .mario_x(mario_x), .mario_y(mario_y),
    .req_valid(req_valid), .req_slot(req_slot), .req_x(req_x), .req_dir(req_dir),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_x(rsp_x), .rsp_dir(rsp_dir),
    .rsp_hit(rsp_hit), .rsp_stomped(rsp_stomped),
    .goomba_x(goomba_x), .goomba_alive(goomba_alive),
    .lose(lose), .tick_overrun(tick_overrun), .rsp_timeout(rsp_timeout)
  );

  always #5 vga_clock = ~vga_clock;

  // Mover: records each accepted request and answers it in the following cycle.
  always begin
    @(negedge vga_clock);
    #1;
    rsp_valid   = 1'b0;
    rsp_hit     = 1'b0;
    rsp_stomped = 1'b0;
    if (inject_rsp) begin
      rsp_valid  = 1'b1;
      rsp_x      = 32'sd123;
      rsp_hit    = 1'b1;
      inject_rsp = 1'b0;
    end else if (pend) begin
      rsp_valid   = 1'b1;
      rsp_x       = pend_x + mv_dx;
      rsp_dir     = pend_dir;
      rsp_stomped = (pend_slot == mv_stomp_slot);
      rsp_hit     = mv_hit || (pend_slot == mv_stomp_slot);
      pend        = 1'b0;
    end
    if (req_valid && req_ready) begin
      req_log.push_back(int'(req_slot));
      req_xlog.push_back(int'(req_x));
      req_dlog.push_back(int'(req_dir));
      if (mv_respond) begin
        pend      = 1'b1;
        pend_x    = req_x;
        pend_dir  = req_dir;
        pend_slot = int'(req_slot);
      end
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int qget(input int q [$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge vga_clock);
  endtask

  task automatic tick_pulse();
    @(negedge vga_clock);
    movement_tick = 1'b1;
    @(negedge vga_clock);
    movement_tick = 1'b0;
  endtask

  task automatic sweep();
    req_log.delete();
    req_xlog.delete();
    req_dlog.delete();
    tick_pulse();
    cycles(25);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alive"}, goomba_alive, 0);
    for (int i = 0; i < 4; i++) chk({tag, "_x"}, goomba_x[i], 0);
    chk({tag, "_flags"}, {lose, tick_overrun, rsp_timeout}, 0);
    chk({tag, "_req_valid"}, req_valid, 0);
    chk({tag, "_req_x"}, req_x, 0);
  endtask

  initial begin
    #2 reset = 1'b0;
    cycles(2);
    chk_all_zero("reset");
    reset = 1'b1;
    cycles(2);

    // Spawn with period 2: first sweep only advances the counter
    sweep();
    chk("spawn1_alive", goomba_alive, 4'b0000);
    chk("spawn1_reqs", req_log.size(), 0);
    sweep();
    chk("spawn2_alive", goomba_alive, 4'b0001);
    chk("spawn2_x0", goomba_x[0], 600);
    sweep();
    chk("echo_reqs", req_log.size(), 1);
    chk("echo_req_x", qget(req_xlog, 0), 600);
    chk("echo_req_dir", qget(req_dlog, 0), 0);
    sweep();
    chk("spawn_slot1", goomba_alive, 4'b0011);
    chk("spawn_x1", goomba_x[1], 600);
    sweep();
    sweep();
    chk("spawn_slot2", goomba_alive, 4'b0111);

    // Slot 1 is both hit and stomped: stomp wins, slot freed, no loss
    mv_stomp_slot = 1;
    sweep();
    chk("stomp_reqs", req_log.size(), 3);
    chk("stomp_alive", goomba_alive, 4'b0101);
    chk("stomp_lose", lose, 0);

    // Slots 0 and 2 alive, mover walks them left by one
    mv_stomp_slot = -1;
    mv_dx = -1;
    sweep();
    chk("walk_reqs", req_log.size(), 2);
    chk("walk_order0", qget(req_log, 0), 0);
    chk("walk_order1", qget(req_log, 1), 2);
    chk("walk_x0", goomba_x[0], 599);
    chk("walk_x2", goomba_x[2], 599);
    chk("walk_respawn1", goomba_alive, 4'b0111);
    chk("walk_x1", goomba_x[1], 600);

    mv_dx = 0;
    sweep();
    sweep();
    chk("fill_alive", goomba_alive, 4'b1111);
    chk("fill_x3", goomba_x[3], 600);
    sweep();
    sweep();
    chk("full_alive", goomba_alive, 4'b1111);

    // Stalled mover: request must hold while two more ticks arrive
    req_ready = 1'b0;
    tick_pulse();
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", req_valid, 1);
      chk("hold_slot", req_slot, 0);
      chk("hold_x", req_x, 599);
      chk("hold_dir", req_dir, 0);
      movement_tick = (k == 1 || k == 3);
      @(negedge vga_clock);
    end
    movement_tick = 1'b0;
    chk("overrun_flag", tick_overrun, 1);
    req_log.delete();
    req_ready = 1'b1;
    cycles(50);
    chk("pending_sweep_reqs", req_log.size(), 8);
    chk("overrun_no_timeout", rsp_timeout, 0);

    // Silent mover: every slot times out and keeps its position
    mv_respond = 1'b0;
    sweep();
    cycles(70);
    chk("timeout_flag", rsp_timeout, 1);
    chk("timeout_x0", goomba_x[0], 599);
    chk("timeout_x1", goomba_x[1], 600);
    chk("timeout_alive", goomba_alive, 4'b1111);
    chk("timeout_lose", lose, 0);

    // Reset while waiting on the mover
    tick_pulse();
    cycles(3);
    reset = 1'b0;
    cycles(1);
    chk_all_zero("wait_reset");
    reset = 1'b1;
    inject_rsp = 1'b1;
    cycles(5);
    chk("stale_rsp_alive", goomba_alive, 0);
    chk("stale_rsp_lose", lose, 0);

    // Plain hit: lose latches and further ticks are ignored
    mv_respond = 1'b1;
    sweep();
    sweep();
    chk("relive_alive", goomba_alive, 4'b0001);
    mv_hit = 1'b1;
    mv_dx = -5;
    sweep();
    chk("hit_lose", lose, 1);
    chk("hit_x0", goomba_x[0], 595);
    mv_hit = 1'b0;
    sweep();
    chk("lose_no_reqs", req_log.size(), 0);
    chk("lose_frozen_x0", goomba_x[0], 595);
    chk("lose_no_overrun", tick_overrun, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
